// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl
//   Multi-cycle issue sequencer that sits between the EX stage and a
//   combinational single-precision FPU. It accepts one operation at a time
//   and holds operands and control steady on the FPU inputs for an
//   op-dependent number of cycles. It then captures the FPU result and
//   presents it to writeback with a valid/ready handshake. While an
//   operation is in flight, or while its result is unconsumed, it stalls
//   the upstream pipeline.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   flush               synchronous abort; beats issue and completion
//   issue_*             operation request from EX (issue_ready high in IDLE)
//   fpu_*               registered operands/control driven to the FPU
//   fpu_result          combinational FPU result
//   res_*               captured result, destination and illegal flag
//   stall               combinational freeze request to the pipeline
module fpu_issue_ctrl #(
    parameter int WIDTH    = 32,
    parameter int LAT_ADD  = 2,
    parameter int LAT_MUL  = 3,
    parameter int LAT_DIV  = 8,
    parameter int LAT_SQRT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [3:0]       issue_op,
    input  logic [2:0]       issue_func3,
    input  logic             issue_rs1_0,
    input  logic [WIDTH-1:0] issue_a,
    input  logic [WIDTH-1:0] issue_b,
    input  logic [4:0]       issue_rd,
    output logic [WIDTH-1:0] fpu_dataA,
    output logic [WIDTH-1:0] fpu_dataB,
    output logic [2:0]       fpu_func3,
    output logic [3:0]       fpu_op,
    output logic             fpu_rs1_0,
    input  logic [WIDTH-1:0] fpu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [4:0]       res_rd,
    output logic             res_illegal,
    output logic             stall
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       func3_q, func3_d;
    logic [3:0]       op_q, op_d;
    logic             rs1_0_q, rs1_0_d;
    logic [4:0]       rd_q, rd_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic [4:0]       res_rd_q, res_rd_d;
    logic             res_illegal_q, res_illegal_d;

    // Counter preload is LAT-1; every encoding without a dedicated
    // latency (including illegal ones) completes in a single cycle.
    function automatic logic [5:0] lat_cnt(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001: lat_cnt = 6'(LAT_ADD - 1);
            4'b0010:          lat_cnt = 6'(LAT_MUL - 1);
            4'b0011:          lat_cnt = 6'(LAT_DIV - 1);
            4'b0110:          lat_cnt = 6'(LAT_SQRT - 1);
            default:          lat_cnt = 6'd0;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides issue, completion and handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (issue_valid) state_d = BUSY;
                BUSY:    if (cnt_q == 6'd0) state_d = DONE;
                DONE:    if (res_ready) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        issue_ready = (state_q == IDLE);
        res_valid   = (state_q == DONE);
        stall       = (state_q == BUSY)
                    | ((state_q == DONE) & ~res_ready)
                    | (issue_valid & (state_q != IDLE) & (state_q != DONE));
    end

    // Operand latch, latency counter and result capture.
    always_comb begin
        cnt_d         = cnt_q;
        a_d           = a_q;
        b_d           = b_q;
        func3_d       = func3_q;
        op_d          = op_q;
        rs1_0_d       = rs1_0_q;
        rd_d          = rd_q;
        illegal_d     = illegal_q;
        res_data_d    = res_data_q;
        res_rd_d      = res_rd_q;
        res_illegal_d = res_illegal_q;
        if (!flush) begin
            case (state_q)
                IDLE: begin
                    if (issue_valid) begin
                        a_d       = issue_a;
                        b_d       = issue_b;
                        func3_d   = issue_func3;
                        op_d      = issue_op;
                        rs1_0_d   = issue_rs1_0;
                        rd_d      = issue_rd;
                        illegal_d = (issue_op > 4'b1001);
                        cnt_d     = lat_cnt(issue_op);
                    end
                end
                BUSY: begin
                    if (cnt_q == 6'd0) begin
                        // Illegal encodings never forward whatever the FPU drives.
                        res_data_d    = illegal_q ? '0 : fpu_result;
                        res_rd_d      = rd_q;
                        res_illegal_d = illegal_q;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            func3_q       <= '0;
            op_q          <= '0;
            rs1_0_q       <= 1'b0;
            rd_q          <= '0;
            illegal_q     <= 1'b0;
            res_data_q    <= '0;
            res_rd_q      <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            a_q           <= a_d;
            b_q           <= b_d;
            func3_q       <= func3_d;
            op_q          <= op_d;
            rs1_0_q       <= rs1_0_d;
            rd_q          <= rd_d;
            illegal_q     <= illegal_d;
            res_data_q    <= res_data_d;
            res_rd_q      <= res_rd_d;
            res_illegal_q <= res_illegal_d;
        end
    end

    assign fpu_dataA   = a_q;
    assign fpu_dataB   = b_q;
    assign fpu_func3   = func3_q;
    assign fpu_op      = op_q;
    assign fpu_rs1_0   = rs1_0_q;
    assign res_data    = res_data_q;
    assign res_rd      = res_rd_q;
    assign res_illegal = res_illegal_q;

    // Latencies must fit the 6-bit down-counter preload.
    always_ff @(posedge clk) begin
        assert (LAT_ADD >= 1 && LAT_ADD <= 63 && LAT_MUL >= 1 && LAT_MUL <= 63 &&
                LAT_DIV >= 1 && LAT_DIV <= 63 && LAT_SQRT >= 1 && LAT_SQRT <= 63)
            else $error("fpu_issue_ctrl: LAT parameter outside 1..63");
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, flush, issue_valid, issue_ready, issue_rs1_0;
    logic [3:0]  issue_op, fpu_op;
    logic [2:0]  issue_func3, fpu_func3;
    logic [31:0] issue_a, issue_b, fpu_dataA, fpu_dataB, fpu_result, res_data;
    logic [4:0]  issue_rd, res_rd;
    logic        fpu_rs1_0, res_valid, res_ready, res_illegal, stall;

    fpu_issue_ctrl #(
        .WIDTH(32), .LAT_ADD(2), .LAT_MUL(3), .LAT_DIV(8), .LAT_SQRT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_func3(issue_func3), .issue_rs1_0(issue_rs1_0),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .fpu_dataA(fpu_dataA), .fpu_dataB(fpu_dataB), .fpu_func3(fpu_func3),
        .fpu_op(fpu_op), .fpu_rs1_0(fpu_rs1_0), .fpu_result(fpu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_illegal(res_illegal), .stall(stall)
    );

    always #5 clk = ~clk;

    // FPU stand-in: answers only the hand-worked vectors, junk otherwise.
    always_comb begin
        fpu_result = 32'hDEADBEEF;
        if (fpu_op == 4'b0000 && fpu_dataA == 32'h3F800000 && fpu_dataB == 32'h40000000)
            fpu_result = 32'h40400000;
        else if (fpu_op == 4'b0011 && fpu_dataA == 32'h40C00000 && fpu_dataB == 32'h40000000)
            fpu_result = 32'h40400000;
        else if (fpu_op == 4'b0010 && fpu_dataA == 32'h40000000 && fpu_dataB == 32'h40400000)
            fpu_result = 32'h40C00000;
        else if (fpu_op == 4'b0100 && fpu_dataA == 32'h3F800000 && fpu_dataB == 32'hC0000000)
            fpu_result = 32'hBF800000;
        else if (fpu_op == 4'b0110 && fpu_dataA == 32'h40800000)
            fpu_result = 32'h40000000;
    end

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   edge_cnt = 0;
    int   acc_edge = 0;
    logic rv_prev = 1'b0;

    always @(posedge clk) edge_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: each new result presentation is matched against the scoreboard.
    always @(negedge clk) begin
        if (res_valid && !rv_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_res_valid", 32'(res_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", res_data, e.data);
                chk("res_rd", 32'(res_rd), 32'(e.rd));
                chk("res_illegal", 32'(res_illegal), 32'(e.ill));
                chk("latency", 32'(edge_cnt - acc_edge), 32'(e.lat));
            end
        end
        rv_prev = res_valid;
    end

    task automatic do_issue(input logic [3:0] op, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                            input bit expect_res, input logic [31:0] exp_d,
                            input logic exp_ill, input int lat);
        exp_t e;
        @(negedge clk);
        chk("issue_ready_before_issue", 32'(issue_ready), 32'd1);
        issue_valid = 1'b1; issue_op = op; issue_func3 = f3; issue_rs1_0 = 1'b0;
        issue_a = a; issue_b = b; issue_rd = rd;
        if (expect_res) begin
            e.data = exp_d; e.rd = rd; e.ill = exp_ill; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        acc_edge = edge_cnt;
        issue_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!res_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(res_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit hold_ok;
        rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0; issue_func3 = '0;
        issue_rs1_0 = 1'b0; issue_a = '0; issue_b = '0; issue_rd = '0; res_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_fpu_dataA", fpu_dataA, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_issue_ready", 32'(issue_ready), 32'd1);

        // FADD, latency 2, writeback ready
        do_issue(4'b0000, 3'b000, 32'h3F800000, 32'h40000000, 5'd1, 1'b1, 32'h40400000, 1'b0, 2);
        chk("fadd_stall_accept", 32'(stall), 32'd1);
        @(negedge clk); chk("fadd_stall_c1", 32'(stall), 32'd1);
        @(negedge clk); chk("fadd_stall_c2", 32'(stall), 32'd1);
        chk("fadd_not_valid_early", 32'(res_valid), 32'd0);
        @(negedge clk); chk("fadd_valid", 32'(res_valid), 32'd1);
        chk("fadd_stall_done_ready", 32'(stall), 32'd0);
        chk("fadd_issue_ready_done", 32'(issue_ready), 32'd0);
        @(negedge clk); chk("fadd_issue_ready_after", 32'(issue_ready), 32'd1);
        chk("fadd_valid_dropped", 32'(res_valid), 32'd0);

        // FDIV, latency 8, operands held for the whole flight
        do_issue(4'b0011, 3'b000, 32'h40C00000, 32'h40000000, 5'd7, 1'b1, 32'h40400000, 1'b0, 8);
        hold_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fpu_dataA !== 32'h40C00000 || fpu_dataB !== 32'h40000000 ||
                fpu_op !== 4'b0011 || res_valid !== 1'b0) hold_ok = 1'b0;
        end
        chk("fdiv_operands_held", 32'(hold_ok), 32'd1);
        @(negedge clk); chk("fdiv_valid", 32'(res_valid), 32'd1);
        @(negedge clk);

        // FMUL with writeback backpressure; a competing issue must be refused
        res_ready = 1'b0;
        do_issue(4'b0010, 3'b000, 32'h40000000, 32'h40400000, 5'd3, 1'b1, 32'h40C00000, 1'b0, 3);
        wait_valid("fmul_valid_timeout");
        issue_valid = 1'b1; issue_op = 4'b0000; issue_a = 32'h11111111; issue_b = 32'h22222222;
        for (int i = 0; i < 3; i++) begin
            chk("bp_res_data", res_data, 32'h40C00000);
            chk("bp_stall", 32'(stall), 32'd1);
            chk("bp_issue_ready", 32'(issue_ready), 32'd0);
            @(negedge clk);
        end
        chk("bp_still_valid", 32'(res_valid), 32'd1);
        res_ready = 1'b1; issue_valid = 1'b0;
        @(negedge clk);
        chk("bp_idle_after_handshake", 32'(issue_ready), 32'd1);
        chk("bp_valid_dropped", 32'(res_valid), 32'd0);

        // Flush mid-FDIV when the counter reads 4
        do_issue(4'b0011, 3'b000, 32'h40C00000, 32'h40000000, 5'd9, 1'b0, 32'h0, 1'b0, 0);
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_idle", 32'(issue_ready), 32'd1);
        chk("flush_no_valid", 32'(res_valid), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        repeat (10) @(negedge clk);
        do_issue(4'b0100, 3'b000, 32'h3F800000, 32'hC0000000, 5'd4, 1'b1, 32'hBF800000, 1'b0, 1);
        wait_valid("fsgnj_valid_timeout");
        @(negedge clk);

        // Illegal encoding: one cycle, zero data, flag set
        do_issue(4'b1111, 3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd11, 1'b1, 32'h0, 1'b1, 1);
        wait_valid("illegal_valid_timeout");
        @(negedge clk);

        // Reset pulse during FSQRT
        do_issue(4'b0110, 3'b000, 32'h40800000, 32'h0, 5'd12, 1'b0, 32'h0, 1'b0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_fpu_dataA", fpu_dataA, 32'd0);
        chk("rst_mid_fpu_op", 32'(fpu_op), 32'd0);
        chk("rst_mid_res_valid", 32'(res_valid), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_issue_ready", 32'(issue_ready), 32'd1);
        repeat (12) @(negedge clk);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Multi-cycle sequencer between the EX stage and the combinational single-precision FPU. It accepts one FP operation at a time, holds operands and control stable on the FPU inputs for an op-dependent number of cycles, then captures the result and hands it to writeback. It stalls the pipeline while an operation is in flight or its result is unconsumed, and supports pipeline flush.

Parameters:
WIDTH, 32, operand/result width
LAT_ADD, 2, cycles for fpuOp 0000/0001 (FADD/FSUB), range 1..63
LAT_MUL, 3, cycles for fpuOp 0010 (FMUL), range 1..63
LAT_DIV, 8, cycles for fpuOp 0011 (FDIV), range 1..63
LAT_SQRT, 8, cycles for fpuOp 0110 (FSQRT), range 1..63

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of any in-flight or pending op
issue_valid  in  1  EX presents an FP op
issue_ready  out  1  controller can accept; high only in IDLE
issue_op  in  4  fpuOp encoding
issue_func3  in  3  func3 of instruction
issue_rs1_0  in  1  rs2-field bit 0 (signed/unsigned select for FCVT)
issue_a  in  WIDTH  operand A
issue_b  in  WIDTH  operand B
issue_rd  in  5  destination register
fpu_dataA  out  WIDTH  registered operand A to FPU
fpu_dataB  out  WIDTH  registered operand B to FPU
fpu_func3  out  3  registered func3 to FPU
fpu_op  out  4  registered fpuOp to FPU
fpu_rs1_0  out  1  registered select to FPU
fpu_result  in  WIDTH  FPU combinational result
res_valid  out  1  result available
res_ready  in  1  writeback accepts result
res_data  out  WIDTH  captured result
res_rd  out  5  destination of result
res_illegal  out  1  op was an unsupported fpuOp encoding
stall  out  1  freeze upstream pipeline

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, all registered outputs 0; res_valid=0, stall=0, issue_ready=1 after release. Reset mid-operation discards the op; no res_valid.
- States: IDLE, BUSY, DONE.
- IDLE: issue_ready=1. On edge with issue_valid=1: latch op/func3/rs1_0/a/b/rd onto fpu_* and internal rd, set illegal = (issue_op > 4'b1001), load cnt = LAT(op)-1, go BUSY. LAT = 1 for fpuOp 0100, 0101, 0111, 1000, 1001 and for illegal codes.
- BUSY: fpu_* held constant. Each edge: if cnt==0 then res_data <= illegal ? 0 : fpu_result, res_rd <= rd, res_illegal <= illegal, go DONE; else cnt <= cnt-1.
- Latency: res_valid rises exactly LAT(op) edges after the accepting edge.
- DONE: res_valid=1; res_data/res_rd/res_illegal stable until handshake. Edge with res_ready=1 -> IDLE. No new issue is accepted in DONE; the next op is accepted one cycle after the handshake, at the earliest.
- stall = (state==BUSY) | (state==DONE & ~res_ready) | (issue_valid & ~issue_ready & state!=DONE). Combinational.
- flush: highest priority. On any edge with flush=1: go IDLE, res_valid drops next cycle, and any simultaneous issue_valid or completion is ignored. fpu_* retain their last values (don't-care).
- Simultaneous flush and res_ready in DONE: treated as flush; the result is dropped.
- cnt width 6 bits; LAT values outside 1..63 are illegal parameterisation (simulation assertion).
- Implementation must not rely on FPU timing internals; the LAT parameters are the contract.

Test Plan:
- FADD (op 0000), a=0x3F800000, b=0x40000000, LAT_ADD=2, res_ready=1 -> res_valid rises 2 edges after accept, res_data=0x40400000, stall high for 2 cycles, issue_ready again 1 cycle after handshake.
- FDIV (op 0011), a=0x40C00000, b=0x40000000, LAT_DIV=8 -> fpu_dataA/B constant for 8 cycles, res_data=0x40400000 at edge 8, res_rd matches issued rd=5'd7.
- Backpressure: FMUL 0x40000000*0x40400000, res_ready held 0 for 3 cycles after res_valid -> res_data=0x40C00000 stable, stall high throughout, issue_ready 0; IDLE after res_ready=1.
- Flush during FDIV at cnt=4 -> next cycle state IDLE, res_valid never asserts; a following FSGNJ (op 0100, func3 000) completes in 1 cycle.
- Illegal op 4'b1111 -> 1-cycle latency, res_data=0, res_illegal=1.
- rst_n pulsed low mid-FSQRT -> all outputs 0 immediately, issue_ready=1 after release, no res_valid.
